// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg: shared types and sizing helpers for the nibble-serial adder.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of 4-bit adder passes needed for a WIDTH-bit add.
    function automatic int calc_nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

    // Width of the pass counter; at least one bit even for a single pass.
    function automatic int calc_idx_w(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// nibble_add_slice: 4-bit combinational ripple-carry adder slice.
// With NIBBLE_SERIAL_ADDER_OVF_EN defined it also exposes c3, the carry
// into bit 3, so the caller can form the two's-complement overflow flag.
module nibble_add_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic       c3,
`endif
    output logic       cout
);

    logic [4:0] carry_s;

    // Ripple the carry through four full-adder bits.
    always_comb begin
        carry_s    = 5'd0;
        sum        = 4'd0;
        carry_s[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
        end
    end

    assign cout = carry_s[4];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign c3   = carry_s[3];
`endif

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds two WIDTH-bit operands one nibble per clock
// through a single shared 4-bit slice, LSB nibble first, with a registered
// carry between passes and valid/ready handshakes on both sides.
// Optional macro NIBBLE_SERIAL_ADDER_OVF_EN adds the out_ovf signed-overflow output.
module nibble_serial_adder_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             out_cout,
    output logic             out_ovf
`else
    output logic             out_cout
`endif
);

    localparam int NIBBLES = calc_nibbles(WIDTH);
    localparam int IDX_W   = calc_idx_w(WIDTH);

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               cout_r;
    logic [3:0]         slice_sum_s;
    logic               slice_cout_s;
    logic [WIDTH-1:0]   sum_shift_s;
    logic               last_pass_s;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic               slice_c3_s;
    logic               ovf_r;
`endif

    nibble_add_slice u_slice (
        .a    (a_r[NIBBLE_W-1:0]),
        .b    (b_r[NIBBLE_W-1:0]),
        .cin  (carry_r),
        .sum  (slice_sum_s),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .c3   (slice_c3_s),
`endif
        .cout (slice_cout_s)
    );

    assign last_pass_s = (idx_r == IDX_W'(NIBBLES - 1));

    // New nibble enters at the top of the sum register; single-nibble builds just take the slice sum.
    generate
        if (NIBBLES == 1) begin : g_single
            assign sum_shift_s = slice_sum_s;
        end else begin : g_multi
            assign sum_shift_s = {slice_sum_s, sum_r[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    // Controller FSM with operand/sum shift registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cout_r      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        carry_r    <= in_cin;
                        idx_r      <= {IDX_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    sum_r   <= sum_shift_s;
                    a_r     <= a_r >> NIBBLE_W;
                    b_r     <= b_r >> NIBBLE_W;
                    carry_r <= slice_cout_s;
                    if (last_pass_s) begin
                        cout_r      <= slice_cout_s;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        ovf_r       <= slice_c3_s ^ slice_cout_s;
`endif
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Result stays frozen until the consumer takes it.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = sum_r;
    assign out_cout  = cout_r;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign out_ovf   = ovf_r;
`endif

endmodule
